// File: rtl/line_buffer_11rows_pkg.sv
// Shared constants for the 11-row line buffer: window height, number of stored lines, default pixel width.
package line_buffer_11rows_pkg;
  localparam int KERNEL    = 11;
  localparam int NUM_LINES = KERNEL - 1;
  localparam int DEF_PIX_W = 8;
endpackage

// File: rtl/line_buffer_11rows_line_ram.sv
// One image line of storage: synchronous write, combinational read at the same address.
module line_buffer_11rows_line_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read returns the pre-write value, so a chained store shifts a column up one row per beat.
  assign rdata = mem[addr];
endmodule

// File: rtl/line_buffer_11rows.sv
// Raster stream to 11-pixel column taps (S1 = row r-10 ... S11 = row r), one registered column per beat.
// Build option LB_TOP_ZERO_PAD_EN: emit from row 0 with unfilled rows forced to zero.
module line_buffer_11rows
  import line_buffer_11rows_pkg::*;
#(
  parameter int COLS  = 16,
  parameter int ROWS  = 16,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [PIX_W-1:0] data_i,
  output logic             valid_o,
  output logic [PIX_W-1:0] S1_o,
  output logic [PIX_W-1:0] S2_o,
  output logic [PIX_W-1:0] S3_o,
  output logic [PIX_W-1:0] S4_o,
  output logic [PIX_W-1:0] S5_o,
  output logic [PIX_W-1:0] S6_o,
  output logic [PIX_W-1:0] S7_o,
  output logic [PIX_W-1:0] S8_o,
  output logic [PIX_W-1:0] S9_o,
  output logic [PIX_W-1:0] S10_o,
  output logic [PIX_W-1:0] S11_o,
  output logic             row_last_o,
  output logic             frame_done_o
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_FULL = RW'(NUM_LINES);

  logic [CW-1:0]    col_cnt;
  logic [RW-1:0]    row_cnt;
  logic [PIX_W-1:0] wr   [NUM_LINES];
  logic [PIX_W-1:0] rd   [NUM_LINES];
  logic [PIX_W-1:0] rd_g [NUM_LINES];
  logic [PIX_W-1:0] tap  [KERNEL];
  logic             out_en;
  logic             end_of_row;
  logic             end_of_frame;

  assign end_of_row   = (col_cnt == COL_LAST);
  assign end_of_frame = end_of_row && (row_cnt == ROW_LAST);

  for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
    if (k == 0) begin : g_head
      assign wr[k] = data_i;
    end else begin : g_chain
      assign wr[k] = rd[k-1];
    end
    line_buffer_11rows_line_ram #(.DEPTH(COLS), .W(PIX_W)) u_line (
      .clk   (clk),
      .we    (valid_i),
      .addr  (col_cnt),
      .wdata (wr[k]),
      .rdata (rd[k])
    );
  end

`ifdef LB_TOP_ZERO_PAD_EN
  // filled[k] marks that store k holds a row of the current frame.
  logic [NUM_LINES-1:0] filled;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filled <= '0;
    end else if (valid_i && end_of_row) begin
      filled <= end_of_frame ? '0 : {filled[NUM_LINES-2:0], 1'b1};
    end
  end

  assign out_en = 1'b1;
  for (genvar k = 0; k < NUM_LINES; k++) begin : g_pad
    assign rd_g[k] = filled[k] ? rd[k] : '0;
  end
`else
  assign out_en = (row_cnt >= ROW_FULL);
  for (genvar k = 0; k < NUM_LINES; k++) begin : g_pass
    assign rd_g[k] = rd[k];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      valid_o      <= 1'b0;
      row_last_o   <= 1'b0;
      frame_done_o <= 1'b0;
      for (int k = 0; k < KERNEL; k++) tap[k] <= '0;
    end else begin
      valid_o      <= valid_i && out_en;
      row_last_o   <= valid_i && out_en && end_of_row;
      frame_done_o <= valid_i && end_of_frame;
      if (valid_i) begin
        tap[KERNEL-1] <= data_i;
        for (int k = 1; k <= NUM_LINES; k++) tap[KERNEL-1-k] <= rd_g[k-1];
        col_cnt <= end_of_row ? '0 : col_cnt + 1'b1;
        if (end_of_row) row_cnt <= end_of_frame ? '0 : row_cnt + 1'b1;
      end
    end
  end

  assign S1_o  = tap[0];
  assign S2_o  = tap[1];
  assign S3_o  = tap[2];
  assign S4_o  = tap[3];
  assign S5_o  = tap[4];
  assign S6_o  = tap[5];
  assign S7_o  = tap[6];
  assign S8_o  = tap[7];
  assign S9_o  = tap[8];
  assign S10_o = tap[9];
  assign S11_o = tap[10];
endmodule

// File: tb/tb_line_buffer_11rows.sv
// Bench for line_buffer_11rows (default build): image-array reference model, directed and random frames.
module tb_line_buffer_11rows;
  localparam int COLS = 16;
  localparam int ROWS = 16;
  localparam int W    = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic [W-1:0] data_i;
  logic         valid_o, row_last_o, frame_done_o;
  logic [W-1:0] S1_o, S2_o, S3_o, S4_o, S5_o, S6_o, S7_o, S8_o, S9_o, S10_o, S11_o;
  logic [W-1:0] s [11];

  line_buffer_11rows #(.COLS(COLS), .ROWS(ROWS), .PIX_W(W)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .valid_o(valid_o),
    .S1_o(S1_o), .S2_o(S2_o), .S3_o(S3_o), .S4_o(S4_o), .S5_o(S5_o), .S6_o(S6_o),
    .S7_o(S7_o), .S8_o(S8_o), .S9_o(S9_o), .S10_o(S10_o), .S11_o(S11_o),
    .row_last_o(row_last_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  assign s[0] = S1_o;  assign s[1] = S2_o;  assign s[2]  = S3_o;  assign s[3] = S4_o;
  assign s[4] = S5_o;  assign s[5] = S6_o;  assign s[6]  = S7_o;  assign s[7] = S8_o;
  assign s[8] = S9_o;  assign s[9] = S10_o; assign s[10] = S11_o;

  int checks = 0;
  int errors = 0;

  // Reference model: the current frame as a plain image plus the raster position.
  logic [W-1:0] img [ROWS][COLS];
  int           mr, mc;
  logic [W-1:0] exp_tap [11];
  bit           tap_known;
  int           vcount;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_row_last"}, row_last_o, 0);
    chk({tag, "_frame_done"}, frame_done_o, 0);
    for (int j = 0; j < 11; j++) chk($sformatf("%s_S%0d", tag, j + 1), s[j], 0);
  endtask

  task automatic model_reset();
    mr = 0;
    mc = 0;
    tap_known = 1'b1;
    for (int j = 0; j < 11; j++) exp_tap[j] = '0;
  endtask

  // One clock: drive, predict from the image, sample 1 time unit after the edge.
  task automatic step(input bit v, input logic [W-1:0] d);
    bit ev, exp_last, exp_done;
    valid_i  = v;
    data_i   = d;
    ev       = v && (mr >= 10);
    exp_last = ev && (mc == COLS - 1);
    exp_done = v && (mr == ROWS - 1) && (mc == COLS - 1);
    if (v) begin
      if (ev) begin
        exp_tap[10] = d;
        for (int j = 0; j < 10; j++) exp_tap[j] = img[mr - 10 + j][mc];
        tap_known = 1'b1;
      end else begin
        tap_known = 1'b0;
      end
      img[mr][mc] = d;
      mc++;
      if (mc == COLS) begin
        mc = 0;
        mr = (mr + 1) % ROWS;
      end
    end
    @(posedge clk);
    #1;
    chk($sformatf("valid_o@%0d,%0d", mr, mc), valid_o, ev);
    chk("row_last_o", row_last_o, exp_last);
    chk("frame_done_o", frame_done_o, exp_done);
    if (valid_o) vcount++;
    if (tap_known)
      for (int j = 0; j < 11; j++) chk($sformatf("S%0d", j + 1), s[j], exp_tap[j]);
  endtask

  // Stream pixels until the model reaches (stop_r, stop_c) or a frame completes.
  task automatic run(input bit ramp, input int bubble_pct, input int stop_r, input int stop_c);
    int pixels, iters;
    bit at_first;
    pixels = 0;
    iters  = 0;
    vcount = 0;
    while (pixels < ROWS * COLS && !(mr == stop_r && mc == stop_c) && iters < 5000) begin
      iters++;
      if ($urandom_range(99) < bubble_pct) begin
        step(1'b0, W'($urandom));
      end else begin
        at_first = ramp && mr == 10 && mc == 0;
        step(1'b1, ramp ? W'(mr * 16 + mc) : W'($urandom));
        pixels++;
        if (at_first) begin
          chk("first_S1", S1_o, 8'h00);
          chk("first_S6", S6_o, 8'h50);
          chk("first_S11", S11_o, 8'hA0);
        end
      end
    end
    if (iters >= 5000) chk("run_budget", iters, 0);
  endtask

  initial begin
    rst     = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      data_i = W'($urandom);
      chk_zero("reset");
    end
    rst = 1'b0;
    model_reset();

    // Gapless ramp frame, then a random-data frame with ~30% bubbles.
    run(1'b1, 0, -1, -1);
    chk("valid_per_frame_gapless", vcount, 96);
    run(1'b0, 30, -1, -1);
    chk("valid_per_frame_bubbles", vcount, 96);
    step(1'b0, 8'h00);

    // Abort a frame at (12,5) with an asynchronous reset.
    run(1'b0, 30, 12, 5);
    valid_i = 1'b0;
    rst     = 1'b1;
    #2;
    chk_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    run(1'b0, 30, -1, -1);
    chk("valid_per_frame_after_reset", vcount, 96);
    run(1'b1, 10, -1, -1);
    chk("valid_per_frame_ramp2", vcount, 96);
    step(1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
